// File: rtl/dbg_clk_gen.sv
// Debug clock generator: NUM_CLKS dividers of i_clk whose limits sweep every table combination.
// All outputs registered (index update 1 cycle after request); i_hold freezes dividers only.
module dbg_clk_gen #(
  parameter int NUM_CLKS   = 4,
  parameter int CLK_WDH    = 17,
  parameter int NUM_LIMS   = 7,
  parameter logic [NUM_LIMS*CLK_WDH-1:0] LIM_TABLE =
    {17'd65536, 17'd4096, 17'd1024, 17'd64, 17'd16, 17'd4, 17'd2},
  parameter int ROT_PERIOD = 250000,
  localparam int IDX_WDH   = (NUM_LIMS > 2) ? $clog2(NUM_LIMS) : 1
) (
  input  logic                        i_clk,
  input  logic                        reset,
  input  logic                        i_hold,
  input  logic                        i_rotate_en,
  input  logic                        i_step,
  output logic [NUM_CLKS-1:0]         o_dclk,
  output logic [NUM_CLKS-1:0]         o_rise,
  output logic [NUM_CLKS*IDX_WDH-1:0] o_lims_idxs,
  output logic                        o_rot_wrap
);

  localparam int ROT_W = $clog2(ROT_PERIOD);
  localparam logic [ROT_W-1:0]   ROT_LAST = ROT_W'(ROT_PERIOD - 1);
  localparam logic [IDX_WDH-1:0] IDX_LAST = IDX_WDH'(NUM_LIMS - 1);

  logic [NUM_CLKS-1:0][CLK_WDH-1:0] cnt_q, cnt_d;
  logic [NUM_CLKS-1:0][IDX_WDH-1:0] idx_q, idx_d;
  logic [NUM_CLKS-1:0][CLK_WDH-1:0] lim;
  logic [NUM_CLKS-1:0]              dclk_q, dclk_d;
  logic [NUM_CLKS-1:0]              rise_q, rise_d;
  logic [ROT_W-1:0]                 rot_q, rot_d;
  logic                             wrap_q, wrap_d;
  logic                             adv;
  logic                             carry;
  logic                             all_max;

  // Mux-based lookup keeps unused index codes (non power-of-two tables) well defined.
  function automatic logic [CLK_WDH-1:0] lim_of(input logic [IDX_WDH-1:0] idx);
    logic [CLK_WDH-1:0] r;
    r = LIM_TABLE[CLK_WDH-1:0];
    for (int j = 0; j < NUM_LIMS; j++) begin
      if (idx == IDX_WDH'(j)) r = LIM_TABLE[j*CLK_WDH +: CLK_WDH];
    end
    return r;
  endfunction

  always_comb begin
    adv = i_step | (i_rotate_en & (rot_q == ROT_LAST));
    if (adv)              rot_d = '0;
    else if (i_rotate_en) rot_d = rot_q + ROT_W'(1);
    else                  rot_d = rot_q;

    carry   = adv;
    all_max = 1'b1;
    for (int k = 0; k < NUM_CLKS; k++) begin
      idx_d[k] = idx_q[k];
      if (idx_q[k] != IDX_LAST) all_max = 1'b0;
      if (carry) begin
        if (idx_q[k] == IDX_LAST) begin
          idx_d[k] = '0;
        end else begin
          idx_d[k] = idx_q[k] + IDX_WDH'(1);
          carry    = 1'b0;
        end
      end
    end
    wrap_d = adv & all_max;
  end

  // ">=" lets a channel whose limit just shrank below its count wrap immediately.
  always_comb begin
    for (int k = 0; k < NUM_CLKS; k++) begin
      lim[k]    = lim_of(idx_q[k]);
      cnt_d[k]  = cnt_q[k];
      dclk_d[k] = dclk_q[k];
      rise_d[k] = 1'b0;
      if (!i_hold) begin
        if (cnt_q[k] >= lim[k] - CLK_WDH'(1)) begin
          cnt_d[k]  = '0;
          dclk_d[k] = ~dclk_q[k];
          rise_d[k] = ~dclk_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CLK_WDH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      dclk_q <= '0;
      rise_q <= '0;
      rot_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      dclk_q <= dclk_d;
      rise_q <= rise_d;
      rot_q  <= rot_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_dclk      = dclk_q;
  assign o_rise      = rise_q;
  assign o_lims_idxs = idx_q;
  assign o_rot_wrap  = wrap_q;

endmodule

// File: tb/tb_dbg_clk_gen.sv
// Scoreboard bench for dbg_clk_gen: 2 channels, table {8,4,2}, rotation period 20.
module tb_dbg_clk_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold;
  logic       rot_en;
  logic       step;
  logic [1:0] dclk;
  logic [1:0] rise;
  logic [3:0] idxs;
  logic       wrap;

  dbg_clk_gen #(
    .NUM_CLKS  (2),
    .CLK_WDH   (17),
    .NUM_LIMS  (3),
    .LIM_TABLE ({17'd8, 17'd4, 17'd2}),
    .ROT_PERIOD(20)
  ) dut (
    .i_clk      (clk),
    .reset      (rst),
    .i_hold     (hold),
    .i_rotate_en(rot_en),
    .i_step     (step),
    .o_dclk     (dclk),
    .o_rise     (rise),
    .o_lims_idxs(idxs),
    .o_rot_wrap (wrap)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge n is the first one whose results are seen with cyc == n.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int       c;
    logic [3:0] idx;
    logic     w;
  } adv_t;

  adv_t adv_q[$];
  int   rq0[$];
  int   rq1[$];
  bit   rise_chk = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] prev_idx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got an event at cycle %0d, required none", name, cyc);
  endtask

  task automatic push_adv(input int c, input logic [3:0] idx, input logic w);
    adv_t e;
    e.c = c; e.idx = idx; e.w = w;
    adv_q.push_back(e);
  endtask

  // Monitor: every index change or wrap pulse, and every rise inside a window, pops an expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_idx = '0;
    end else begin
      if (idxs !== prev_idx || wrap !== 1'b0) begin
        if (adv_q.size() == 0) begin
          unexpected("adv_event");
        end else begin
          adv_t e;
          e = adv_q.pop_front();
          check("adv_cycle", 32'(cyc), 32'(e.c));
          check("adv_idx", 32'(idxs), 32'(e.idx));
          check("adv_wrap", 32'(wrap), 32'(e.w));
        end
        prev_idx = idxs;
      end
      if (rise_chk) begin
        if (rise[0]) begin
          if (rq0.size() == 0) unexpected("rise0_event");
          else check("rise0_cycle", 32'(cyc), 32'(rq0.pop_front()));
          check("rise0_dclk", 32'(dclk[0]), 32'd1);
        end
        if (rise[1]) begin
          if (rq1.size() == 0) unexpected("rise1_event");
          else check("rise1_cycle", 32'(cyc), 32'(rq1.pop_front()));
          check("rise1_dclk", 32'(dclk[1]), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic close_rise();
    rise_chk = 1'b0;
    check("rise0_left", 32'(rq0.size()), 32'd0);
    check("rise1_left", 32'(rq1.size()), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_dclk"}, 32'(dclk), 32'd0);
    check({tag, "_rise"}, 32'(rise), 32'd0);
    check({tag, "_idx"},  32'(idxs), 32'd0);
    check({tag, "_wrap"}, 32'(wrap), 32'd0);
  endtask

  initial begin
    logic [3:0] seq [8];
    int r0a [5];
    int r1a [7];
    seq = '{4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b0000};
    r0a = '{2, 6, 10, 16, 24};
    r1a = '{2, 6, 10, 14, 18, 22, 26};

    rst = 1'b1; hold = 1'b0; rot_en = 1'b0; step = 1'b0;
    tick(); tick();
    chk_reset("por");

    // Base clocks at limit 2, then one step widens channel 0 to half-period 4.
    foreach (r0a[i]) rq0.push_back(r0a[i]);
    foreach (r1a[i]) rq1.push_back(r1a[i]);
    rise_chk = 1'b1;
    rst = 1'b0;
    run_to(11);
    check("dclk_c11", 32'(dclk), 32'b11);
    run_to(12);
    step = 1'b1;
    push_adv(13, 4'b0001, 1'b0);
    tick();
    step = 1'b0;
    run_to(28);
    close_rise();

    // Remaining eight steps walk the odometer back to 00 with a single wrap pulse.
    for (int i = 0; i < 8; i++) begin
      step = 1'b1;
      push_adv(29 + 2*i, seq[i], (i == 7));
      tick();
      step = 1'b0;
      tick();
    end
    run_to(46);

    // Automatic rotation, a 10-cycle pause, and a step coinciding with expiry.
    rst = 1'b1; rot_en = 1'b1;
    tick(); tick();
    push_adv(20, 4'b0001, 1'b0);
    push_adv(40, 4'b0010, 1'b0);
    push_adv(70, 4'b0100, 1'b0);
    push_adv(90, 4'b0101, 1'b0);
    push_adv(110, 4'b0110, 1'b0);
    rst = 1'b0;
    run_to(47);
    rot_en = 1'b0;
    run_to(57);
    rot_en = 1'b1;
    run_to(89);
    step = 1'b1;
    tick();
    step = 1'b0;
    run_to(112);
    rot_en = 1'b0;
    check("rot_left", 32'(adv_q.size()), 32'd0);
    rst = 1'b1;
    tick(); tick();

    // Limit shrink 8 -> 2 at count 7, then a 15-cycle hold with a step inside it.
    rq0.push_back(8);  rq0.push_back(12); rq0.push_back(16); rq0.push_back(39);
    rq1.push_back(2);  rq1.push_back(6);  rq1.push_back(14); rq1.push_back(37);
    push_adv(1, 4'b0001, 1'b0);
    push_adv(2, 4'b0010, 1'b0);
    push_adv(7, 4'b0100, 1'b0);
    push_adv(25, 4'b0101, 1'b0);
    rise_chk = 1'b1;
    rst = 1'b0;
    step = 1'b1;
    tick(); tick();
    step = 1'b0;
    run_to(6);
    step = 1'b1;
    tick();
    step = 1'b0;
    run_to(17);
    hold = 1'b1;
    run_to(24);
    step = 1'b1;
    tick();
    step = 1'b0;
    run_to(28);
    check("dclk_hold", 32'(dclk), 32'b11);
    run_to(32);
    hold = 1'b0;
    run_to(41);
    close_rise();
    check("dclk_prerst", 32'(dclk), 32'b01);
    rst = 1'b1;
    #1;
    chk_reset("midrun");

    // Restart after mid-run reset must match the power-up behaviour.
    tick(); tick();
    rq0.push_back(2); rq0.push_back(6); rq0.push_back(10);
    rq1.push_back(2); rq1.push_back(6); rq1.push_back(10);
    rise_chk = 1'b1;
    rst = 1'b0;
    run_to(11);
    check("dclk_restart", 32'(dclk), 32'b11);
    run_to(12);
    close_rise();
    tick();
    check("adv_left", 32'(adv_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
